// File: rtl/reg_file_8x16_pkg.sv
// ============================================================================
// Module   : reg_file_8x16_pkg
// Brief    : Shared sizing constants and write-select classification.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_file_8x16_pkg;

    localparam int              RF_DATA_W    = 16;
    localparam int              RF_NREG      = 8;
    localparam int              RF_ADDR_W    = 3;
    localparam logic [15:0]     RF_RESET_VAL = 16'h0000;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_LEGAL = 2'd1,
        WR_MULTI = 2'd2
    } wr_kind_t;

    function automatic wr_kind_t wr_classify(input logic [RF_NREG-1:0] we);
        if (we == '0) begin
            return WR_IDLE;
        end else if ((we & (we - 1'b1)) == '0) begin
            return WR_LEGAL;
        end else begin
            return WR_MULTI;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_8x16_read_port.sv
// ============================================================================
// Module   : rf_read_port
// Brief    : Combinational read port with write-through bypass and ready flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_read_port
    import reg_file_8x16_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [NREG*DATA_W-1:0] i_regs,
    input  logic [NREG-1:0]        i_pend,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [NREG-1:0]        i_wr_sel,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_rdy
);

    logic w_hit;

    // i_wr_sel is already zeroed for illegal writes, so bypass never fires on them
    assign w_hit  = i_wr_sel[i_addr];
    assign o_data = w_hit ? i_wr_data : i_regs[int'(i_addr)*DATA_W +: DATA_W];
    assign o_rdy  = ~i_pend[i_addr] | w_hit;

endmodule

`default_nettype wire

// File: rtl/reg_file_8x16.sv
// ============================================================================
// Module   : reg_file_8x16
// Brief    : 8x16 register file, one-hot write, two bypassed read ports,
//            pending-producer scoreboard and sticky multi-hot error flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREG-1:0]   we_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_rdy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_rdy_b,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic [NREG-1:0]   pend,
    output logic              we_err
);

    logic [DATA_W-1:0]      r_regs [NREG];
    logic [NREG-1:0]        r_pend;
    logic                   r_we_err;

    wr_kind_t               w_kind;
    logic [NREG-1:0]        w_wr_sel;
    logic [NREG-1:0]        w_iss_sel;
    logic [NREG*DATA_W-1:0] w_regs_flat;

    always_comb begin
        w_kind    = wr_classify(we_onehot);
        w_wr_sel  = (w_kind == WR_LEGAL) ? we_onehot : '0;
        w_iss_sel = iss_valid ? (NREG'(1) << iss_dst) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= DATA_W'(RF_RESET_VAL);
            end
            r_pend   <= '0;
            r_we_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
            // Clear on write-back first, then set on issue, so a same-cycle issue wins
            r_pend <= (r_pend & ~w_wr_sel) | w_iss_sel;
            if (w_kind == WR_MULTI) begin
                r_we_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_flat
            assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    rf_read_port #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .i_regs    (w_regs_flat),
        .i_pend    (r_pend),
        .i_addr    (rd_addr_a),
        .i_wr_sel  (w_wr_sel),
        .i_wr_data (wr_data),
        .o_data    (rd_data_a),
        .o_rdy     (rd_rdy_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .i_regs    (w_regs_flat),
        .i_pend    (r_pend),
        .i_addr    (rd_addr_b),
        .i_wr_sel  (w_wr_sel),
        .i_wr_data (wr_data),
        .o_data    (rd_data_b),
        .o_rdy     (rd_rdy_b)
    );

    assign pend   = r_pend;
    assign we_err = r_we_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_8x16.sv
// ============================================================================
// Module   : tb_reg_file_8x16
// Brief    : Self-checking bench: directed table, corner sequences, random vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_8x16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  we_onehot;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a, rd_addr_b, iss_dst;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_rdy_a, rd_rdy_b, iss_valid;
    logic [7:0]  pend;
    logic        we_err;

    int n_vec = 0;
    int n_err = 0;

    reg_file_8x16 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .we_onehot (we_onehot),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_rdy_a  (rd_rdy_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_rdy_b  (rd_rdy_b),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .pend      (pend),
        .we_err    (we_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  we;
        logic [15:0] data;
        logic [2:0]  addr_a;
        logic [2:0]  addr_b;
        logic        iss_v;
        logic [2:0]  iss_d;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_rdy_a;
        logic        exp_rdy_b;
        logic [7:0]  exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    // Reference model: architectural state only
    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic [7:0] we, input logic [15:0] d,
                         input logic [2:0] aa, input logic [2:0] ab,
                         input logic iv, input logic [2:0] id);
        @(negedge clk);
        reset_n   = rn;
        we_onehot = we;
        wr_data   = d;
        rd_addr_a = aa;
        rd_addr_b = ab;
        iss_valid = iv;
        iss_dst   = id;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcount(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int low_index(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a, input logic [7:0] we, input logic [15:0] d);
        if (popcount(we) == 1 && low_index(we) == int'(a)) return d;
        return m_regs[a];
    endfunction

    function automatic logic m_rdy(input logic [2:0] a, input logic [7:0] we);
        if (popcount(we) == 1 && low_index(we) == int'(a)) return 1'b1;
        return ~m_pend[a];
    endfunction

    task automatic m_update(input logic rn, input logic [7:0] we, input logic [15:0] d,
                            input logic iv, input logic [2:0] id);
        if (!rn) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_pend = 8'h00;
            m_err  = 1'b0;
        end else begin
            if (popcount(we) == 1) begin
                m_regs[low_index(we)] = d;
                m_pend[low_index(we)] = 1'b0;
            end
            if (popcount(we) > 1) m_err = 1'b1;
            if (iv) m_pend[id] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0]  r_we;
        logic [15:0] r_d;
        logic [2:0]  r_aa, r_ab, r_id;
        logic        r_iv, r_rn;
        int          sel;

        reset_n = 1'b0; we_onehot = 8'h00; wr_data = 16'h0; rd_addr_a = 3'd0;
        rd_addr_b = 3'd0; iss_valid = 1'b0; iss_dst = 3'd0;

        tbl[0] = '{8'h08, 16'hBEEF, 3'd3, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{8'h00, 16'h0000, 3'd3, 3'd0, 1'b1, 3'd5, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 8'h20, 1'b0};
        tbl[2] = '{8'h00, 16'h0000, 3'd5, 3'd3, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'h20, 1'b0};
        tbl[3] = '{8'h20, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0, 16'h1234, 16'h1234, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{8'h04, 16'h00A5, 3'd2, 3'd5, 1'b1, 3'd2, 16'h00A5, 16'h1234, 1'b1, 1'b1, 8'h04, 1'b0};
        tbl[5] = '{8'h00, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'h00A5, 16'h00A5, 1'b0, 1'b0, 8'h04, 1'b0};
        tbl[6] = '{8'h41, 16'hFFFF, 3'd0, 3'd6, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 8'h04, 1'b1};
        tbl[7] = '{8'h00, 16'h0000, 3'd6, 3'd2, 1'b0, 3'd0, 16'h0000, 16'h00A5, 1'b1, 1'b0, 8'h04, 1'b1};
        tbl[8] = '{8'h04, 16'h5555, 3'd2, 3'd2, 1'b0, 3'd0, 16'h5555, 16'h5555, 1'b1, 1'b1, 8'h00, 1'b1};

        // Reset state
        drive(1'b0, 8'h00, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        tick();
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_err", 32'(we_err), 32'h0);
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 8'h00, 16'h0, 3'(a), 3'(7 - a), 1'b0, 3'd0);
            chk("reset_rd_a", 32'(rd_data_a), 32'h0);
            chk("reset_rd_b", 32'(rd_data_b), 32'h0);
            chk("reset_rdy", 32'({rd_rdy_a, rd_rdy_b}), 32'h3);
        end

        // Directed table
        for (int v = 0; v < 9; v++) begin
            drive(1'b1, tbl[v].we, tbl[v].data, tbl[v].addr_a, tbl[v].addr_b, tbl[v].iss_v, tbl[v].iss_d);
            chk($sformatf("tbl%0d_rd_a", v), 32'(rd_data_a), 32'(tbl[v].exp_a));
            chk($sformatf("tbl%0d_rd_b", v), 32'(rd_data_b), 32'(tbl[v].exp_b));
            chk($sformatf("tbl%0d_rdy_a", v), 32'(rd_rdy_a), 32'(tbl[v].exp_rdy_a));
            chk($sformatf("tbl%0d_rdy_b", v), 32'(rd_rdy_b), 32'(tbl[v].exp_rdy_b));
            tick();
            chk($sformatf("tbl%0d_pend", v), 32'(pend), 32'(tbl[v].exp_pend));
            chk($sformatf("tbl%0d_err", v), 32'(we_err), 32'(tbl[v].exp_err));
        end

        // Sticky error over idle cycles, cleared only by reset
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'h00, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
            tick();
            chk("err_sticky", 32'(we_err), 32'h1);
        end
        drive(1'b0, 8'h00, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
        tick();
        chk("err_cleared", 32'(we_err), 32'h0);

        // Reset overriding a same-cycle write and issue
        drive(1'b1, 8'h80, 16'h7777, 3'd7, 3'd7, 1'b1, 3'd7);
        tick();
        chk("pre_rst_pend", 32'(pend), 32'h80);
        drive(1'b0, 8'h80, 16'h9999, 3'd7, 3'd7, 1'b1, 3'd7);
        tick();
        chk("rst_mid_pend", 32'(pend), 32'h00);
        drive(1'b1, 8'h00, 16'h0, 3'd7, 3'd7, 1'b0, 3'd0);
        chk("rst_mid_reg7", 32'(rd_data_a), 32'h0);
        chk("rst_mid_rdy7", 32'(rd_rdy_b), 32'h1);

        // Randomised traffic against the model
        m_update(1'b0, 8'h00, 16'h0, 1'b0, 3'd0);
        for (int n = 0; n < 600; n++) begin
            sel  = int'($urandom_range(0, 99));
            r_d  = 16'($urandom);
            r_aa = 3'($urandom);
            r_ab = ($urandom_range(0, 3) == 0) ? r_aa : 3'($urandom);
            r_iv = 1'($urandom);
            r_id = 3'($urandom);
            r_rn = 1'b1;
            if (sel < 30) begin
                r_we = 8'h00;
            end else if (sel < 85) begin
                r_we = 8'h01 << $urandom_range(0, 7);
            end else if (sel < 95) begin
                r_we = 8'($urandom) | 8'h11 << $urandom_range(0, 3);
            end else begin
                r_rn = 1'b0;
                r_we = 8'h00;
            end
            drive(r_rn, r_we, r_d, r_aa, r_ab, r_iv, r_id);
            chk("rnd_rd_a", 32'(rd_data_a), 32'(m_read(r_aa, r_we, r_d)));
            chk("rnd_rd_b", 32'(rd_data_b), 32'(m_read(r_ab, r_we, r_d)));
            chk("rnd_rdy_a", 32'(rd_rdy_a), 32'(m_rdy(r_aa, r_we)));
            chk("rnd_rdy_b", 32'(rd_rdy_b), 32'(m_rdy(r_ab, r_we)));
            tick();
            m_update(r_rn, r_we, r_d, r_iv, r_id);
            chk("rnd_pend", 32'(pend), 32'(m_pend));
            chk("rnd_err", 32'(we_err), 32'(m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
